// File: rtl/bcd_pkg.sv
// Shared constants and FSM state type for the reverse double-dabble BCD-to-binary converter.
package bcd_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] BCD_CORR_THRESH = 4'd8;
    localparam logic [DIGIT_W-1:0] BCD_CORR_VAL    = 4'd3;
    localparam logic [DIGIT_W-1:0] BCD_MAX_DIGIT   = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_digit_correct.sv
// Per-digit correction for reverse double dabble: a digit of 8 or more after the
// right shift carried in a half-ten from above, so it is pulled back by 3.
import bcd_pkg::*;

module bcd_digit_correct (
    input  logic [DIGIT_W-1:0] din,
    output logic [DIGIT_W-1:0] dout
);

    assign dout = (din >= BCD_CORR_THRESH) ? din - BCD_CORR_VAL : din;

endmodule

// File: rtl/bcd_to_binary.sv
// Iterative BCD-to-binary converter, one shift/correct step per clock.
// Optional feature: define BCD_TO_BINARY_DIGIT_CHECK_EN to flag non-decimal input digits.
import bcd_pkg::*;

module bcd_to_binary #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DIGIT_W*DIGITS-1:0] bcd,
    output logic                      out_valid,
    output logic [BIN_W-1:0]          binary,
    output logic                      err
);

    localparam int WORK_W = DIGIT_W * DIGITS + BIN_W;
    localparam int CNT_W  = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);

    state_t            state;
    logic [WORK_W-1:0] work;
    logic [WORK_W-1:0] work_shift;
    logic [WORK_W-1:0] work_step;
    logic [CNT_W-1:0]  cnt;
    logic [BIN_W-1:0]  result;

    // The binary field is only shifted; every BCD digit is corrected independently.
    assign work_shift = work >> 1;
    assign work_step[BIN_W-1:0] = work_shift[BIN_W-1:0];

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_correct u_correct (
            .din  (work_shift[BIN_W + DIGIT_W*g +: DIGIT_W]),
            .dout (work_step [BIN_W + DIGIT_W*g +: DIGIT_W])
        );
    end

    assign in_ready = (state == IDLE);

`ifdef BCD_TO_BINARY_DIGIT_CHECK_EN
    logic bad_digit;
    logic err_flag;

    // NOTE: give every always_comb output a default first so no path leaves it unassigned (latch).
    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[DIGIT_W*i +: DIGIT_W] > BCD_MAX_DIGIT) begin
                bad_digit = 1'b1;
            end
        end
    end

    assign result = err_flag ? '0 : work_step[BIN_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            err_flag <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (state == IDLE && in_valid) begin
                err_flag <= bad_digit;
            end
            if (state == SHIFT && cnt == LAST_STEP) begin
                err <= err_flag;
            end
        end
    end
`else
    assign result = work_step[BIN_W-1:0];
    assign err    = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            // NOTE: the working register is reset too; a dropped conversion must not leak into the next.
            work      <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            binary    <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work  <= {bcd, {BIN_W{1'b0}}};
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    work <= work_step;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST_STEP) begin
                        binary    <= result;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
